// File: rtl/regfile_pkg.sv
// Shared defaults, clear-sequencer state type and a width helper for the register file.
package regfile_pkg;

  localparam int DATA_W_DEF   = 64;
  localparam int DEPTH_DEF    = 32;
  localparam int ZERO_REG_DEF = DEPTH_DEF - 1;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  // Bits needed to index `value` entries.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sweep: walks every index once, then raises ready.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_idx,
  output logic              ready
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  clr_state_e state_reg;

  // A reset mid-sweep simply restarts the walk from index 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= CLEAR;
      clr_en    <= 1'b1;
      clr_idx   <= '0;
      ready     <= 1'b0;
    end else begin
      case (state_reg)
        CLEAR: begin
          if (clr_idx == LAST_IDX) begin
            state_reg <= IDLE;
            clr_en    <= 1'b0;
            clr_idx   <= '0;
            ready     <= 1'b1;
          end else begin
            clr_idx <= clr_idx + ADDR_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// 2-read/1-write register file with write-to-read bypass, a hardwired zero entry
// and a per-register pending-write scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int ADDR_W   = clog2(DEPTH),
  parameter int ZERO_REG = DEPTH - 1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  output logic              ready,
  input  logic [ADDR_W-1:0] r1,
  input  logic [ADDR_W-1:0] r2,
  output logic [DATA_W-1:0] r1_data,
  output logic [DATA_W-1:0] r2_data,
  output logic              r1_busy,
  output logic              r2_busy,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              write_E,
  input  logic [ADDR_W-1:0] r_write,
  input  logic [DATA_W-1:0] data_in
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic              clr_en;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_ok;
  logic              iss_ok;
  logic [ADDR_W-1:0] rd_idx  [2];
  logic [DATA_W-1:0] rd_data [2];
  logic [1:0]        rd_busy;

  // True for indices that hold real state: in range and not the zero register.
  function automatic logic idx_live(input logic [ADDR_W-1:0] idx);
    return (32'(idx) < DEPTH) && (32'(idx) != ZERO_REG);
  endfunction

  regfile_clr_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr_seq (
    .clk     (clk),
    .reset   (reset),
    .clr_en  (clr_en),
    .clr_idx (clr_idx),
    .ready   (ready)
  );

  assign wr_ok  = write_E && ready && idx_live(r_write);
  assign iss_ok = iss_valid && ready && idx_live(iss_rd);

  // The clear sweep owns the single write port until ready rises.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_idx] <= '0;
    end else if (wr_ok) begin
      mem[r_write] <= data_in;
    end
  end

  // Issue beats writeback on the same index: the register stays pending.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
    assign busy_next[gi] = (iss_ok && 32'(iss_rd) == gi) ? 1'b1 :
                           (wr_ok && 32'(r_write) == gi) ? 1'b0 : busy_reg[gi];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= '0;
    end else begin
      busy_reg <= busy_next;
    end
  end

  assign rd_idx[0] = r1;
  assign rd_idx[1] = r2;

  // Zero/out-of-range indices are filtered first so they read 0 even before reset.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_data[p] = '0;
      rd_busy[p] = 1'b0;
      if (idx_live(rd_idx[p]) && ready) begin
        rd_busy[p] = busy_reg[rd_idx[p]];
        if (BYPASS && wr_ok && r_write == rd_idx[p]) begin
          rd_data[p] = data_in;
        end else begin
          rd_data[p] = mem[rd_idx[p]];
        end
      end
    end
  end

  assign r1_data = rd_data[0];
  assign r2_data = rd_data[1];
  assign r1_busy = rd_busy[0];
  assign r2_busy = rd_busy[1];

endmodule
